// File: rtl/ex_div_pkg.sv
// Shared definitions for the EX-stage multi-cycle divider: FSM state codes and
// handshake level names used by the divider and the EX stage driving it.
package ex_div_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/ex_div.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per clock on operand
// magnitudes, sign fix-up on completion, result held until EX drops start_i.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int               CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  div_state_e            r_state;
  div_state_e            w_next_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [2*DATA_W-1:0]   r_work;      // {partial remainder, dividend/quotient bits}
  logic [DATA_W-1:0]     r_divisor;
  logic                  r_signed;
  logic                  r_neg1;
  logic                  r_neg2;
  logic [2*DATA_W-1:0]   r_result;
  logic                  r_ready;

  logic                  w_go;
  logic [DATA_W-1:0]     w_abs1;
  logic [DATA_W-1:0]     w_abs2;
  logic [DATA_W:0]       w_partial;
  logic [DATA_W:0]       w_trial;
  logic [DATA_W-1:0]     w_quo_raw;
  logic [DATA_W-1:0]     w_rem_raw;
  logic [DATA_W-1:0]     w_quo;
  logic [DATA_W-1:0]     w_rem;

  assign w_go   = (start_i == DIV_START) && !annul_i;
  assign w_abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign w_abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // The partial remainder is always below the divisor, so one extra bit holds the shift.
  assign w_partial = r_work[2*DATA_W-1:DATA_W-1];
  assign w_trial   = w_partial - {1'b0, r_divisor};

  assign w_quo_raw = r_work[DATA_W-1:0];
  assign w_rem_raw = r_work[2*DATA_W-1:DATA_W];
  assign w_quo     = (r_signed && (r_neg1 ^ r_neg2)) ? -w_quo_raw : w_quo_raw;
  assign w_rem     = (r_signed && r_neg1) ? -w_rem_raw : w_rem_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= DIV_FREE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_next_state and no latch is inferred.
    w_next_state = r_state;
    unique case (r_state)
      DIV_FREE:    if (w_go) w_next_state = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
      DIV_BY_ZERO: w_next_state = annul_i ? DIV_FREE : DIV_END;
      DIV_ON: begin
        if (annul_i)                 w_next_state = DIV_FREE;
        else if (r_cnt == CNT_LAST)  w_next_state = DIV_END;
      end
      DIV_END:     if (start_i == DIV_STOP) w_next_state = DIV_FREE;
      default:     w_next_state = DIV_FREE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_signed  <= 1'b0;
      r_neg1    <= 1'b0;
      r_neg2    <= 1'b0;
      r_result  <= '0;
      r_ready   <= DIV_RESULT_NOT_READY;
    end else begin
      unique case (r_state)
        DIV_FREE: begin
          r_result <= '0;
          r_ready  <= DIV_RESULT_NOT_READY;
          if (w_go && (opdata2_i != '0)) begin
            r_work    <= {{DATA_W{1'b0}}, w_abs1};
            r_divisor <= w_abs2;
            r_signed  <= signed_div_i;
            r_neg1    <= opdata1_i[DATA_W-1];
            r_neg2    <= opdata2_i[DATA_W-1];
            r_cnt     <= '0;
          end
        end
        DIV_BY_ZERO: begin
          if (!annul_i) begin
            r_result <= '0;
            r_ready  <= DIV_RESULT_READY;
          end
        end
        DIV_ON: begin
          if (annul_i) begin
            r_cnt <= '0;
          end else if (r_cnt != CNT_LAST) begin
            if (w_trial[DATA_W]) r_work <= {r_work[2*DATA_W-2:0], 1'b0};
            else                 r_work <= {w_trial[DATA_W-1:0], r_work[DATA_W-2:0], 1'b1};
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_result <= {w_rem, w_quo};
            r_ready  <= DIV_RESULT_READY;
            r_cnt    <= '0;
          end
        end
        DIV_END: begin
          if (start_i == DIV_STOP) begin
            r_result <= '0;
            r_ready  <= DIV_RESULT_NOT_READY;
          end
        end
        default: ;
      endcase
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule
